// File: rtl/rysy_bus_arbiter.sv
// rysy_bus_arbiter: shares the rysy data bus between two masters with round-robin
// priority, bounded bus locking and tracking of which master owns the returned read data.
//
// state | meaning
// IDLE  | no lock held, round-robin between requesters
// OWN0  | master 0 holds the bus, master 1 is stalled
// OWN1  | master 1 holds the bus, master 0 is stalled
module rysy_bus_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             m0_req,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [3:0]       m0_be,
  input  logic             m0_we,
  input  logic             m0_lock,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,

  input  logic             m1_req,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic [3:0]       m1_be,
  input  logic             m1_we,
  input  logic             m1_lock,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,

  output logic [WIDTH-1:0] s_addr,
  output logic [WIDTH-1:0] s_wdata,
  output logic [3:0]       s_be,
  output logic             s_we,
  input  logic [WIDTH-1:0] s_rdata,

  output logic             lock_timeout
);

  localparam int            CW       = $clog2(MAX_LOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          rsel_q, rsel_d;
  logic          gnt0, gnt1;
  logic          timeout;

  // Grants are combinational and forced low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
      OWN0:    gnt0 = m0_req;
      OWN1:    gnt1 = m1_req;
      default: ;
    endcase
    if (!rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    timeout    = 1'b0;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (gnt0 && m0_lock) begin
          state_d    = OWN0;
          lock_cnt_d = '0;
        end else if (gnt1 && m1_lock) begin
          state_d    = OWN1;
          lock_cnt_d = '0;
        end
      end
      // The counter runs even when the owner is idle so a silent owner cannot starve the other side.
      OWN0: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (gnt0 && !m0_lock) begin
          state_d = IDLE;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d = IDLE;
          timeout = 1'b1;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (gnt1 && !m1_lock) begin
          state_d = IDLE;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d = IDLE;
          timeout = 1'b1;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rvalid_d = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
  assign rsel_d   = rvalid_d ? gnt1 : rsel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rsel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rsel_q     <= rsel_d;
    end
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_be    = 4'b0000;
    s_we    = 1'b0;
    if (gnt0) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_be    = m0_be;
      s_we    = m0_we;
    end else if (gnt1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_be    = m1_be;
      s_we    = m1_we;
    end
  end

  assign m0_gnt       = gnt0;
  assign m1_gnt       = gnt1;
  assign m0_rvalid    = rvalid_q & ~rsel_q;
  assign m1_rvalid    = rvalid_q & rsel_q;
  assign m0_rdata     = s_rdata;
  assign m1_rdata     = s_rdata;
  assign lock_timeout = timeout;

endmodule

// File: tb/tb_rysy_bus_arbiter.sv
// Bench for rysy_bus_arbiter: directed scenarios, a transaction-level model checked every
// cycle, and a sync-RAM stand-in on the slave side.
module tb_rysy_bus_arbiter;

  localparam int WIDTH    = 32;
  localparam int MAX_LOCK = 16;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_we;
  logic        lock_timeout;

  int tests = 0;
  int fails = 0;

  rysy_bus_arbiter #(.WIDTH(WIDTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_we(m0_we), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_we(m1_we), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we), .s_rdata(s_rdata),
    .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave stand-in: synchronous RAM driven purely by the DUT's slave port.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (s_we) begin
      for (int b = 0; b < 4; b++)
        if (s_be[b]) ram[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
    s_rdata <= ram[s_addr[5:2]];
  end

  // Model: who owns the bus, when the lock began, who won last, which read is in flight.
  logic [31:0] exp_mem [16];
  int          m_own   = -1;
  int          m_last  = 1;
  int          m_pend  = -1;
  int          m_entry = 0;
  int          m_cyc   = 0;
  logic [31:0] m_pdata = '0;
  int          e0, e1, g, eto, own_b;
  bit          rel, lk, wr;
  logic [31:0] ea, ew, ta;
  logic [3:0]  eb;

  always @(negedge clk) begin
    e0 = 0; e1 = 0; eto = 0; g = -1;
    if (rst) begin
      if (m_own == 0)      e0 = int'(m0_req);
      else if (m_own == 1) e1 = int'(m1_req);
      else if (m0_req && m1_req) begin
        if (m_last == 1) e0 = 1; else e1 = 1;
      end else begin
        e0 = int'(m0_req);
        e1 = int'(m1_req);
      end
    end
    if (e0 == 1) g = 0; else if (e1 == 1) g = 1;
    ea = 0; ew = 0; eb = 0; wr = 0; lk = 0;
    if (g == 0) begin ea = m0_addr; ew = m0_wdata; eb = m0_be; wr = m0_we; lk = m0_lock; end
    if (g == 1) begin ea = m1_addr; ew = m1_wdata; eb = m1_be; wr = m1_we; lk = m1_lock; end
    if (rst && m_own >= 0) begin
      rel = (g == m_own) && !lk;
      eto = (!rel && (m_cyc - m_entry == MAX_LOCK)) ? 1 : 0;
    end
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ew);
    chk("s_be", 32'(s_be), 32'(eb));
    chk("s_we", s_we, 32'(wr));
    chk("lock_timeout", lock_timeout, eto);
    chk("m0_rvalid", m0_rvalid, (rst && m_pend == 0) ? 1 : 0);
    chk("m1_rvalid", m1_rvalid, (rst && m_pend == 1) ? 1 : 0);
    if (rst && m_pend == 0) chk("m0_rdata", m0_rdata, m_pdata);
    if (rst && m_pend == 1) chk("m1_rdata", m1_rdata, m_pdata);

    if (!rst) begin
      m_own = -1; m_last = 1; m_pend = -1;
    end else begin
      own_b = m_own;
      m_pend = -1;
      if (g >= 0) begin
        m_last = g;
        if (m_own == -1 && lk) begin
          m_own = g;
          m_entry = m_cyc;
        end else if (m_own == g && !lk) begin
          m_own = -1;
        end
        ta = ea;
        if (!wr) begin
          m_pend  = g;
          m_pdata = exp_mem[ta[5:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (eb[b]) exp_mem[ta[5:2]][8*b +: 8] = ew[8*b +: 8];
        end
      end
      if (eto == 1) begin
        m_own  = -1;
        m_last = own_b;
      end
    end
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0;
  endtask

  task automatic drive(input int m, input bit req, input bit we, input bit lck,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_lock = lck; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lck; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Owner m locks, goes quiet, other side waits; at the limit cycle owner issues a final access.
  task automatic lock_window(input int m, input bit fin_req, input bit fin_lock, input bit exp_to);
    int early;
    early = 0;
    drive(m, 1, 0, 1, 32'h10, 0);
    #1 chk("lw_entry_gnt", (m == 0) ? m0_gnt : m1_gnt, 1);
    step();
    drive(m, 0, 0, 0, 32'h10, 0);
    drive(1 - m, 1, 0, 0, 32'h18, 0);
    for (int n = 1; n < MAX_LOCK; n++) begin
      #1 if (lock_timeout) early++;
      step();
    end
    drive(m, fin_req, 0, fin_lock, 32'h1C, 0);
    #1;
    chk("lw_timeout", lock_timeout, 32'(exp_to));
    chk("lw_early", early, 0);
    chk("lw_owner_final", (m == 0) ? m0_gnt : m1_gnt, 32'(fin_req));
    chk("lw_other_stalled", (m == 0) ? m1_gnt : m0_gnt, 0);
    step();
    drive(m, 0, 0, 0, 32'h10, 0);
    #1 chk("lw_other_after", (m == 0) ? m1_gnt : m0_gnt, 1);
    step();
    idle_all();
    step();
  endtask

  bit [5:0] gseq;
  int       stall;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 32'hC0DE_0000 | 32'(i);
      exp_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    rst = 0;
    idle_all();
    m0_be = 4'hF; m1_be = 4'hF;
    m0_addr = 32'h20; m1_addr = 32'h24; m0_wdata = 0; m1_wdata = 0;
    m0_req = 1; m1_req = 1;
    #2;
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_saddr", s_addr, 0);
    step(); step();
    idle_all();
    rst = 1;
    step();

    // single master read
    drive(0, 1, 0, 0, 32'h10, 0);
    #1;
    chk("t1_gnt", m0_gnt, 1);
    chk("t1_saddr", s_addr, 32'h10);
    step();
    m0_req = 0;
    m1_be = 4'b0011;
    drive(1, 1, 1, 0, 32'h14, 32'h1111_2222);
    #1;
    chk("t1_rvalid", m0_rvalid, 1);
    chk("t1_rdata", m0_rdata, 32'hC0DE_0004);
    chk("t1_m1rv", m1_rvalid, 0);
    step();
    idle_all();
    m1_be = 4'hF;

    // contention
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 0, 32'h10, 0);
      drive(1, 1, 0, 0, 32'h14, 0);
      #1;
      gseq[i] = m1_gnt;
      chk("t2_onehot", 32'(m0_gnt ^ m1_gnt), 1);
      step();
    end
    idle_all();
    #1;
    chk("t2_seq", 32'(gseq), 32'(6'b101010));
    chk("t2_m1_rvalid", m1_rvalid, 1);
    chk("t2_m1_rdata", m1_rdata, 32'hC0DE_2222);
    step();

    drive(0, 1, 0, 0, 32'h0, 0);
    step();
    idle_all();

    // locked writes by M1 while M0 waits
    stall = 0;
    drive(0, 1, 0, 0, 32'h8, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, (k < 2), 32'h30 + 32'(4*k), 32'hA5A5_0000 + 32'(k));
      #1;
      if (!m0_gnt) stall++;
      chk("t3_m1gnt", m1_gnt, 1);
      step();
    end
    drive(1, 0, 0, 0, 32'h30, 0);
    #1;
    chk("t3_m0gnt", m0_gnt, 1);
    chk("t3_stall", stall, 3);
    step();
    idle_all();

    // idle bus
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_swe", s_we, 0);
      chk("t5_sbe", 32'(s_be), 0);
      chk("t5_saddr", s_addr, 0);
      step();
    end

    lock_window(0, 0, 0, 1);
    lock_window(1, 1, 0, 0);
    lock_window(0, 1, 1, 1);

    // reset while M0 owns the bus with a read in flight
    drive(0, 1, 0, 1, 32'h10, 0);
    step();
    drive(0, 1, 0, 1, 32'h14, 0);
    drive(1, 1, 0, 0, 32'h18, 0);
    #2;
    chk("t6_pre_gnt", m0_gnt, 1);
    chk("t6_pre_rv", m0_rvalid, 1);
    rst = 0;
    #1;
    chk("t6_gnt0", m0_gnt, 0);
    chk("t6_gnt1", m1_gnt, 0);
    chk("t6_rv0", m0_rvalid, 0);
    chk("t6_rv1", m1_rvalid, 0);
    m0_lock = 0;
    step();
    rst = 1;
    #1;
    chk("t6_tie_m0", m0_gnt, 1);
    chk("t6_tie_m1", m1_gnt, 0);
    step();
    m0_req = 0;
    #1 chk("t6_m1_next", m1_gnt, 1);
    step();
    idle_all();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
